// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
//   Instruction fetch from a 256-byte big-endian ROM, an IF/ID pipeline
//   register, and an ARM-style control decoder driven from that register.
//
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   asynchronous, active-low; clears IF/ID while low
//   pc              in   32  fetch address (pc[7:0] addresses the ROM)
//   next_pc         in   32  PC+4 captured alongside the instruction
//   E               in   1   IF/ID load enable (1 = capture, 0 = hold)
//   if_instruction  out  32  combinational ROM word at pc[7:0]
//   instr_out       out  32  registered instruction
//   Next_PC         out  32  registered next_pc
//   instr_i*        out  -   bit-slices of instr_out
//   ALU_OP .. ID_BL out  -   decoded control, combinational from instr_out
//
// Mem has no write port; it is loaded by hierarchical assignment and is
// deliberately untouched by reset.

module fetch_decode_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        E,
  output logic [31:0] if_instruction,
  output logic [31:0] instr_out,
  output logic [31:0] Next_PC,
  output logic [23:0] instr_i23_i0,
  output logic [3:0]  instr_i3_i0,
  output logic [3:0]  instr_i19_i16,
  output logic [3:0]  instr_i31_i28,
  output logic [11:0] instr_i11_i0,
  output logic [3:0]  instr_i15_i12,
  output logic [3:0]  ALU_OP,
  output logic [1:0]  ID_AM,
  output logic        ID_LOAD,
  output logic        ID_MEM_WRITE,
  output logic        STORE_CC,
  output logic        ID_MEM_SIZE,
  output logic        ID_MEM_E,
  output logic        RF_E,
  output logic        ID_B,
  output logic        ID_BL
);

  logic [7:0]  Mem [0:255];

  logic [31:0] r_instr;
  logic [31:0] r_next_pc;

  logic [7:0]  w_a0;
  logic [7:0]  w_a1;
  logic [7:0]  w_a2;
  logic [7:0]  w_a3;
  logic        w_unused_pc;

  // Byte addresses wrap inside the 256-byte space by 8-bit arithmetic.
  assign w_a0 = pc[7:0];
  assign w_a1 = w_a0 + 8'd1;
  assign w_a2 = w_a0 + 8'd2;
  assign w_a3 = w_a0 + 8'd3;
  assign w_unused_pc = ^pc[31:8];

  assign if_instruction = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr   <= 32'h0;
      r_next_pc <= 32'h0;
    end else if (E) begin
      r_instr   <= if_instruction;
      r_next_pc <= next_pc;
    end
  end

  assign instr_out     = r_instr;
  assign Next_PC       = r_next_pc;
  assign instr_i23_i0  = r_instr[23:0];
  assign instr_i3_i0   = r_instr[3:0];
  assign instr_i19_i16 = r_instr[19:16];
  assign instr_i31_i28 = r_instr[31:28];
  assign instr_i11_i0  = r_instr[11:0];
  assign instr_i15_i12 = r_instr[15:12];

  logic [3:0] w_opcode;
  logic       w_is_nop;
  logic       w_is_dp;
  logic       w_is_ls;
  logic       w_is_br;

  assign w_opcode = r_instr[24:21];
  // An all-zero word would otherwise decode as AND r0,r0,r0; treat it as NOP.
  assign w_is_nop = (r_instr == 32'h0);
  // [27:26]=00 with [25]=0, [7]=1, [4]=1 is the multiply/extra load-store space,
  // which this decoder does not support.
  assign w_is_dp  = !w_is_nop && (r_instr[27:26] == 2'b00) &&
                    !(!r_instr[25] && r_instr[7] && r_instr[4]);
  assign w_is_ls  = (r_instr[27:26] == 2'b01);
  assign w_is_br  = (r_instr[27:25] == 3'b101);

  always_comb begin
    ALU_OP       = 4'b0000;
    ID_AM        = 2'b00;
    ID_LOAD      = 1'b0;
    ID_MEM_WRITE = 1'b0;
    STORE_CC     = 1'b0;
    ID_MEM_SIZE  = 1'b0;
    ID_MEM_E     = 1'b0;
    RF_E         = 1'b0;
    ID_B         = 1'b0;
    ID_BL        = 1'b0;
    if (w_is_dp) begin
      ALU_OP   = w_opcode;
      STORE_CC = r_instr[20];
      // TST/TEQ/CMP/CMN (1000-1011) only set flags.
      RF_E     = (w_opcode[3:2] != 2'b10);
      if (r_instr[25])     ID_AM = 2'b00;
      else if (r_instr[4]) ID_AM = 2'b10;
      else                 ID_AM = 2'b11;
    end else if (w_is_ls) begin
      ID_MEM_E     = 1'b1;
      ID_LOAD      = r_instr[20];
      ID_MEM_WRITE = ~r_instr[20];
      ID_MEM_SIZE  = r_instr[22];
      RF_E         = r_instr[20];
      ALU_OP       = r_instr[23] ? 4'b0100 : 4'b0010;
      if (!r_instr[25])                 ID_AM = 2'b01;
      else if (r_instr[11:4] == 8'h00)  ID_AM = 2'b10;
      else                              ID_AM = 2'b11;
    end else if (w_is_br) begin
      ID_B  = 1'b1;
      ID_BL = r_instr[24];
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        E;
  logic [31:0] if_instruction;
  logic [31:0] instr_out;
  logic [31:0] Next_PC;
  logic [23:0] instr_i23_i0;
  logic [3:0]  instr_i3_i0;
  logic [3:0]  instr_i19_i16;
  logic [3:0]  instr_i31_i28;
  logic [11:0] instr_i11_i0;
  logic [3:0]  instr_i15_i12;
  logic [3:0]  ALU_OP;
  logic [1:0]  ID_AM;
  logic        ID_LOAD;
  logic        ID_MEM_WRITE;
  logic        STORE_CC;
  logic        ID_MEM_SIZE;
  logic        ID_MEM_E;
  logic        RF_E;
  logic        ID_B;
  logic        ID_BL;

  int total = 0;
  int bad   = 0;

  fetch_decode_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc), .E(E),
    .if_instruction(if_instruction), .instr_out(instr_out), .Next_PC(Next_PC),
    .instr_i23_i0(instr_i23_i0), .instr_i3_i0(instr_i3_i0),
    .instr_i19_i16(instr_i19_i16), .instr_i31_i28(instr_i31_i28),
    .instr_i11_i0(instr_i11_i0), .instr_i15_i12(instr_i15_i12),
    .ALU_OP(ALU_OP), .ID_AM(ID_AM), .ID_LOAD(ID_LOAD), .ID_MEM_WRITE(ID_MEM_WRITE),
    .STORE_CC(STORE_CC), .ID_MEM_SIZE(ID_MEM_SIZE), .ID_MEM_E(ID_MEM_E),
    .RF_E(RF_E), .ID_B(ID_B), .ID_BL(ID_BL)
  );

  // {ALU_OP, ID_AM, LOAD, MEM_WRITE, STORE_CC, MEM_SIZE, MEM_E, RF_E, B, BL}
  logic [13:0] ctl;
  assign ctl = {ALU_OP, ID_AM, ID_LOAD, ID_MEM_WRITE, STORE_CC,
                ID_MEM_SIZE, ID_MEM_E, RF_E, ID_B, ID_BL};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] w);
    logic [7:0] b;
    b = a;
    dut.Mem[b] = w[31:24]; b = b + 8'd1;
    dut.Mem[b] = w[23:16]; b = b + 8'd1;
    dut.Mem[b] = w[15:8];  b = b + 8'd1;
    dut.Mem[b] = w[7:0];
  endtask

  task automatic fetch(input logic [31:0] a);
    pc      = a;
    next_pc = a + 32'd4;
    E       = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_instr, input logic [13:0] exp_ctl);
    fetch(a);
    chk({tag, "_instr"}, instr_out, exp_instr);
    chk({tag, "_npc"}, Next_PC, a + 32'd4);
    chk({tag, "_ctl"}, {18'h0, ctl}, {18'h0, exp_ctl});
  endtask

  initial begin
    reset   = 1'b0;
    E       = 1'b0;
    pc      = 32'h0;
    next_pc = 32'h0;
    for (int i = 0; i < 256; i++) dut.Mem[i] = 8'h00;
    load_word(8'd0,  32'hE2821005);
    load_word(8'd4,  32'hE3510000);
    load_word(8'd8,  32'hE5921004);
    load_word(8'd12, 32'hE5421004);
    load_word(8'd16, 32'hEB000004);
    load_word(8'd20, 32'hEA000004);
    load_word(8'd24, 32'hE0812003);
    load_word(8'd28, 32'hE0812313);
    load_word(8'd32, 32'hE0000091);
    load_word(8'd36, 32'hE7921003);
    load_word(8'd40, 32'hE7921103);
    load_word(8'd44, 32'hE8BD0001);
    load_word(8'd48, 32'hEE000000);
    load_word(8'd52, 32'hE3110001);
    load_word(8'd56, 32'hE3811001);
    dut.Mem[8'hFE] = 8'hAA;
    dut.Mem[8'hFF] = 8'hBB;
    #1;

    chk("rst_instr", instr_out, 32'h0);
    chk("rst_npc", Next_PC, 32'h0);
    chk("rst_ctl", {18'h0, ctl}, 32'h0);

    chk("rom_comb_0", if_instruction, 32'hE2821005);
    pc = 32'h0000_0080;
    #1;
    chk("rom_unwritten", if_instruction, 32'h0);
    pc = 32'hFFFF_FF00;
    #1;
    chk("rom_pc_hi_ignored", if_instruction, 32'hE2821005);

    pc = 32'h0; next_pc = 32'h4; E = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_edge", instr_out, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_cap_instr", instr_out, 32'hE2821005);
    chk("first_cap_npc", Next_PC, 32'h4);
    chk("add_imm_ctl", {18'h0, ctl}, {18'h0, 14'b0100_00_00000100});
    chk("i15_12", {28'h0, instr_i15_i12}, 32'h1);
    chk("i19_16", {28'h0, instr_i19_i16}, 32'h2);
    chk("i3_0", {28'h0, instr_i3_i0}, 32'h5);
    chk("i11_0", {20'h0, instr_i11_i0}, 32'h005);
    chk("i31_28", {28'h0, instr_i31_i28}, 32'hE);
    chk("i23_0", {8'h0, instr_i23_i0}, 32'h821005);

    fetch_chk("cmp",      32'd4,  32'hE3510000, 14'b1010_00_00100000);
    fetch_chk("ldr",      32'd8,  32'hE5921004, 14'b0100_01_10001100);
    fetch_chk("strb",     32'd12, 32'hE5421004, 14'b0010_01_01011000);
    fetch_chk("bl",       32'd16, 32'hEB000004, 14'b0000_00_00000011);
    chk("bl_i23_0", {8'h0, instr_i23_i0}, 32'h000004);
    fetch_chk("b",        32'd20, 32'hEA000004, 14'b0000_00_00000010);
    fetch_chk("add_reg",  32'd24, 32'hE0812003, 14'b0100_11_00000100);
    fetch_chk("add_rsr",  32'd28, 32'hE0812313, 14'b0100_10_00000100);
    fetch_chk("mul",      32'd32, 32'hE0000091, 14'b0000_00_00000000);
    fetch_chk("ldr_reg",  32'd36, 32'hE7921003, 14'b0100_10_10001100);
    fetch_chk("ldr_shft", 32'd40, 32'hE7921103, 14'b0100_11_10001100);
    fetch_chk("ldm",      32'd44, 32'hE8BD0001, 14'b0000_00_00000000);
    fetch_chk("cop",      32'd48, 32'hEE000000, 14'b0000_00_00000000);
    fetch_chk("tst",      32'd52, 32'hE3110001, 14'b1000_00_00100000);
    fetch_chk("orr",      32'd56, 32'hE3811001, 14'b1100_00_00000100);
    fetch_chk("nop",      32'h80, 32'h00000000, 14'b0000_00_00000000);

    fetch(32'd0);
    E = 1'b0; pc = 32'd8; next_pc = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_instr", instr_out, 32'hE2821005);
      chk("hold_npc", Next_PC, 32'h4);
    end
    chk("hold_rom_tracks", if_instruction, 32'hE5921004);
    pc = 32'h0000_00FE;
    #1;
    chk("rom_wrap", if_instruction, 32'hAABBE282);

    fetch(32'd0);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_instr", instr_out, 32'h0);
    chk("async_rst_npc", Next_PC, 32'h0);
    chk("async_rst_ctl", {18'h0, ctl}, 32'h0);
    chk("async_rst_slice", {28'h0, instr_i15_i12}, 32'h0);
    chk("rom_kept", if_instruction, 32'hE2821005);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("recap_instr", instr_out, 32'hE2821005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
